// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: state encodings shared by the step controller, its LED logic and the bench
package proc_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncy button and pulses Press once per stable 0->1 transition
module btn_debounce #(
    parameter int DebCycles = 1000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Raw,
    output logic Press
);
    localparam int CW = DebCycles > 1 ? $clog2(DebCycles) : 1;
    localparam logic [CW-1:0] LAST = CW'(DebCycles - 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic stable, stable_q;
    // the stable value only follows the button once it has disagreed for a full window
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync     <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync     <= {sync[0], Raw};
            stable_q <= stable;
            if (sync[1] == stable) cnt <= '0;
            else if (cnt == LAST) begin
                stable <= sync[1];
                cnt    <= '0;
            end else cnt <= cnt + CW'(1);
        end
    end
    assign Press = stable & ~stable_q;
endmodule

// File: rtl/proc_step_ctrl.sv
// proc_step_ctrl: turns the divided clock into single-cycle CPU enables with run, step and halt modes
module proc_step_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int DebCycles = 1000000,
    parameter int CntW      = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            SlowClk,
    input  logic            BtnStep,
    input  logic            ModeRun,
    input  logic            Halt,
    output logic            CpuEn,
    output logic [CntW-1:0] StepCount,
    output logic [1:0]      State
);
    logic [2:0] slow_q;
    logic [1:0] mode_q;
    logic tick, mode, press, en_nxt;
    state_t st, st_nxt;
    btn_debounce #(.DebCycles(DebCycles)) u_deb (
        .Clk   (Clk),
        .Rst   (Rst),
        .Raw   (BtnStep),
        .Press (press)
    );
    assign tick  = slow_q[1] & ~slow_q[2];
    assign mode  = mode_q[1];
    assign State = st;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            slow_q    <= '0;
            mode_q    <= '0;
            st        <= IDLE;
            CpuEn     <= 1'b0;
            StepCount <= '0;
        end else begin
            slow_q <= {slow_q[1:0], SlowClk};
            mode_q <= {mode_q[0], ModeRun};
            st     <= st_nxt;
            CpuEn  <= en_nxt;
            if (en_nxt && StepCount != '1) StepCount <= StepCount + CntW'(1);
        end
    end
    // Halt is checked ahead of the tick so a same-cycle halt swallows the pulse
    always_comb begin
        st_nxt = st;
        en_nxt = 1'b0;
        case (st)
            IDLE:   st_nxt = mode ? RUN : press ? STEP : IDLE;
            RUN: begin
                st_nxt = Halt ? HALTED : !mode ? IDLE : RUN;
                en_nxt = !Halt && mode && tick;
            end
            STEP: begin
                st_nxt = Halt ? HALTED : tick ? IDLE : STEP;
                en_nxt = !Halt && tick;
            end
            HALTED: st_nxt = (press && !mode) ? IDLE : HALTED;
            default: st_nxt = IDLE;
        endcase
    end
endmodule
